// File: rtl/uart_engine_pkg.sv
// uart_engine_pkg: shared frame constants, FSM encodings and bit-period derivation.
package uart_engine_pkg;
   localparam int FRAME_BITS = 10;
   localparam int DATA_BITS = 8;
   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAITHIGH} rx_state_e;
   function automatic int bit_period(input int clk_hz, input int bps);
      return clk_hz / bps;
   endfunction
   function automatic int half_period(input int bp);
      return bp / 2;
   endfunction
endpackage

// File: rtl/uart_engine_if.sv
// uart_engine_if: byte-level front-end bus between the UART register block and the serial engine.
interface uart_engine_if;
   logic [7:0] txdata;
   logic txbegin;
   logic txbusy;
   logic [7:0] rxdata;
   logic rxrecv;
   logic data_read;
   modport master(output txdata, txbegin, data_read, input txbusy, rxdata, rxrecv);
   modport slave(input txdata, txbegin, data_read, output txbusy, rxdata, rxrecv);
endinterface

// File: rtl/uart_engine_rx_deser.sv
// uart_rx_deser: synchronises rx, deserialises 8N1 frames, rejects start glitches and framing errors.
module uart_rx_deser import uart_engine_pkg::*; #(
   parameter int BITPERIOD = 16
) (
   input logic clk,
   input logic rst,
   input logic rx,
   output logic valid,
   output logic [DATA_BITS-1:0] data
);
   localparam int CW = $clog2(BITPERIOD + 1);
   localparam logic [CW-1:0] FULL = CW'(BITPERIOD - 1);
   localparam logic [CW-1:0] HALF = CW'(half_period(BITPERIOD) - 1);
   rx_state_e state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0] bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [1:0] sync_q, sync_d;
   logic rx_s, expire;
   assign rx_s = sync_q[1];
   assign expire = cnt_q == '0;
   assign data = shift_q;
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RX_IDLE;
         cnt_q <= '0;
         bit_q <= '0;
         shift_q <= '0;
         sync_q <= 2'b11;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         bit_q <= bit_d;
         shift_q <= shift_d;
         sync_q <= sync_d;
      end
   end
   // counter runs down to zero; each zero is a mid-bit sample point
   always_comb begin
      state_d = state_q;
      cnt_d = expire ? cnt_q : cnt_q - 1'b1;
      bit_d = bit_q;
      shift_d = shift_q;
      sync_d = {sync_q[0], rx};
      valid = 1'b0;
      case (state_q)
         RX_IDLE: if (!rx_s) begin
            state_d = RX_START;
            cnt_d = HALF;
         end
         RX_START: if (expire) begin
            state_d = rx_s ? RX_IDLE : RX_DATA;
            cnt_d = FULL;
            bit_d = '0;
         end
         RX_DATA: if (expire) begin
            shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
            cnt_d = FULL;
            bit_d = bit_q + 1'b1;
            state_d = bit_q == 3'(DATA_BITS - 1) ? RX_STOP : RX_DATA;
         end
         RX_STOP: if (expire) begin
            valid = rx_s;
            state_d = rx_s ? RX_IDLE : RX_WAITHIGH;
         end
         RX_WAITHIGH: if (rx_s) state_d = RX_IDLE;
         default: state_d = RX_IDLE;
      endcase
   end
endmodule

// File: rtl/uart_engine.sv
// uart_engine: 8N1 transmitter, receive holding register and drain logic; UART_RTS_FLOW_EN drives rts from the
// holding-register full flag, otherwise rts is tied low.
module uart_engine import uart_engine_pkg::*; #(
   parameter int CLK = 28000000,
   parameter int BPS = 115200
) (
   input logic clk,
   input logic rst,
   uart_engine_if.slave bus,
   input logic rx,
   output logic tx,
   output logic rts
);
   localparam int BITPERIOD = bit_period(CLK, BPS);
   localparam int CW = $clog2(BITPERIOD + 1);
   localparam logic [CW-1:0] FULL = CW'(BITPERIOD - 1);
   tx_state_e tx_state_q, tx_state_d;
   logic [CW-1:0] tx_cnt_q, tx_cnt_d;
   logic [2:0] tx_bit_q, tx_bit_d;
   logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
   logic tx_q, tx_d;
   logic [DATA_BITS-1:0] rxdata_q, rxdata_d;
   logic rxrecv_q, rxrecv_d;
   logic data_read_q, data_read_d;
   logic rx_valid, tx_last, drain;
   logic [DATA_BITS-1:0] rx_byte;
   uart_rx_deser #(.BITPERIOD(BITPERIOD)) u_rx (
      .clk(clk),
      .rst(rst),
      .rx(rx),
      .valid(rx_valid),
      .data(rx_byte)
   );
   assign tx = tx_q;
   assign tx_last = tx_cnt_q == FULL;
   assign drain = data_read_q & ~bus.data_read;
   assign bus.txbusy = tx_state_q != TX_IDLE;
   assign bus.rxdata = rxdata_q;
   assign bus.rxrecv = rxrecv_q;
`ifdef UART_RTS_FLOW_EN
   assign rts = rxrecv_q;
`else
   assign rts = 1'b0;
`endif
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_state_q <= TX_IDLE;
         tx_cnt_q <= '0;
         tx_bit_q <= '0;
         tx_shift_q <= '0;
         tx_q <= 1'b1;
         rxdata_q <= '0;
         rxrecv_q <= 1'b0;
         data_read_q <= 1'b0;
      end else begin
         tx_state_q <= tx_state_d;
         tx_cnt_q <= tx_cnt_d;
         tx_bit_q <= tx_bit_d;
         tx_shift_q <= tx_shift_d;
         tx_q <= tx_d;
         rxdata_q <= rxdata_d;
         rxrecv_q <= rxrecv_d;
         data_read_q <= data_read_d;
      end
   end
   // tx is registered from the next state so the line changes exactly on state entry
   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d = tx_cnt_q + 1'b1;
      tx_bit_d = tx_bit_q;
      tx_shift_d = tx_shift_q;
      case (tx_state_q)
         TX_IDLE: begin
            tx_cnt_d = '0;
            if (bus.txbegin) begin
               tx_state_d = TX_START;
               tx_shift_d = bus.txdata;
            end
         end
         TX_START: if (tx_last) begin
            tx_state_d = TX_DATA;
            tx_cnt_d = '0;
            tx_bit_d = '0;
         end
         TX_DATA: if (tx_last) begin
            tx_cnt_d = '0;
            tx_bit_d = tx_bit_q + 1'b1;
            tx_shift_d = tx_shift_q >> 1;
            tx_state_d = tx_bit_q == 3'(DATA_BITS - 1) ? TX_STOP : TX_DATA;
         end
         TX_STOP: if (tx_last) begin
            tx_state_d = TX_IDLE;
            tx_cnt_d = '0;
         end
         default: tx_state_d = TX_IDLE;
      endcase
      tx_d = tx_state_d == TX_START ? 1'b0 : tx_state_d == TX_DATA ? tx_shift_d[0] : 1'b1;
   end
   // a commit coinciding with the drain edge loads the new byte and keeps the register full
   always_comb begin
      data_read_d = bus.data_read;
      rxrecv_d = rx_valid | (rxrecv_q & ~drain);
      rxdata_d = rx_valid & (~rxrecv_q | drain) ? rx_byte : rxdata_q;
   end
endmodule

// File: tb/tb_uart_engine.sv
// tb_uart_engine: table vectors, hand corner sequences and random frames against a frame-level model.
module tb_uart_engine;
   import uart_engine_pkg::*;
   localparam int BP = 28000000 / 1750000;
   logic clk, rst, rx, tx, rts;
   int cyc = 0;
   int total = 0;
   int bad = 0;
   logic m_full;
   logic [7:0] m_data;
   uart_engine_if bus ();
   uart_engine #(.CLK(28000000), .BPS(1750000)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave),
      .rx(rx),
      .tx(tx),
      .rts(rts)
   );
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not complete, cycle=%0d", cyc);
      $fatal(1, "watchdog");
   end
   typedef struct packed {
      logic [7:0] tx_b;
      logic [7:0] rx_b;
      logic stop_ok;
      logic drain_first;
      logic exp_recv;
      logic [7:0] exp_data;
   } vec_t;
   vec_t vecs [6];
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask
   function automatic logic exp_rts();
`ifdef UART_RTS_FLOW_EN
      return m_full;
`else
      return 1'b0;
`endif
   endfunction
   task automatic wait_cycle(input int t);
      while (cyc < t) @(negedge clk);
   endtask
   task automatic send_tx(input logic [7:0] b);
      logic [9:0] f;
      int n;
      f = {1'b1, b, 1'b0};
      n = cyc;
      bus.txdata = b;
      bus.txbegin = 1'b1;
      wait_cycle(n + 1);
      bus.txbegin = 1'b0;
      chk("tx_start_edge", tx, 0);
      chk("txbusy_rise", bus.txbusy, 1);
      for (int i = 0; i < FRAME_BITS; i++) begin
         wait_cycle(n + 1 + i * BP + BP / 2);
         chk($sformatf("tx_bit%0d_of_%02h", i, b), tx, f[i]);
      end
      wait_cycle(n + 10 * BP);
      chk("txbusy_last", bus.txbusy, 1);
      wait_cycle(n + 1 + 10 * BP);
      chk("txbusy_fall", bus.txbusy, 0);
      chk("tx_idle", tx, 1);
   endtask
   task automatic rx_frame(input logic [7:0] b, input logic stop);
      logic [9:0] f;
      int d;
      f = {stop, b, 1'b0};
      d = cyc;
      for (int i = 0; i < FRAME_BITS; i++) begin
         rx = f[i];
         wait_cycle(d + (i + 1) * BP);
      end
      rx = 1'b1;
   endtask
   task automatic drain(input int len);
      bus.data_read = 1'b1;
      for (int i = 0; i < len; i++) begin
         @(negedge clk);
         chk("rxdata_hold", bus.rxdata, m_data);
      end
      bus.data_read = 1'b0;
      chk("rxrecv_before_clear", bus.rxrecv, m_full);
      @(negedge clk);
      m_full = 1'b0;
      chk("rxrecv_drained", bus.rxrecv, 0);
      chk("rts_drained", rts, exp_rts());
   endtask
   task automatic check_hold(input string tag);
      chk({tag, "_rxrecv"}, bus.rxrecv, m_full);
      chk({tag, "_rxdata"}, bus.rxdata, m_data);
      chk({tag, "_rts"}, rts, exp_rts());
   endtask
   initial begin
      int d;
      logic [7:0] rb, tb_b;
      logic stop;
      vecs[0] = '{8'hA5, 8'h3C, 1'b1, 1'b0, 1'b1, 8'h3C};
      vecs[1] = '{8'h5A, 8'h11, 1'b1, 1'b1, 1'b1, 8'h11};
      vecs[2] = '{8'hC3, 8'h22, 1'b1, 1'b0, 1'b1, 8'h11};
      vecs[3] = '{8'h00, 8'h77, 1'b0, 1'b1, 1'b0, 8'h11};
      vecs[4] = '{8'hFF, 8'h5A, 1'b1, 1'b0, 1'b1, 8'h5A};
      vecs[5] = '{8'h81, 8'h00, 1'b1, 1'b1, 1'b1, 8'h00};
      rst = 1'b1;
      rx = 1'b1;
      bus.txbegin = 1'b0;
      bus.txdata = 8'h00;
      bus.data_read = 1'b0;
      m_full = 1'b0;
      m_data = 8'h00;
      repeat (3) @(negedge clk);
      chk("reset_tx", tx, 1);
      chk("reset_txbusy", bus.txbusy, 0);
      check_hold("reset");
      rst = 1'b0;
      repeat (2) @(negedge clk);
      for (int v = 0; v < 6; v++) begin
         if (vecs[v].drain_first) drain(5);
         @(negedge clk);
         fork
            send_tx(vecs[v].tx_b);
            rx_frame(vecs[v].rx_b, vecs[v].stop_ok);
         join
         repeat (4) @(negedge clk);
         chk($sformatf("vec%0d_rxrecv", v), bus.rxrecv, vecs[v].exp_recv);
         chk($sformatf("vec%0d_rxdata", v), bus.rxdata, vecs[v].exp_data);
         if (vecs[v].stop_ok && !m_full) m_data = vecs[v].rx_b;
         if (vecs[v].stop_ok) m_full = 1'b1;
         chk($sformatf("vec%0d_rts", v), rts, exp_rts());
      end
      drain(3);
      rx = 1'b0;
      repeat (4) @(negedge clk);
      rx = 1'b1;
      repeat (200) @(negedge clk);
      check_hold("glitch");
      fork
         rx_frame(8'h42, 1'b1);
      join
      repeat (2) @(negedge clk);
      m_full = 1'b1;
      m_data = 8'h42;
      check_hold("pre_coincide");
      bus.data_read = 1'b1;
      repeat (2) @(negedge clk);
      d = cyc;
      fork
         rx_frame(8'h99, 1'b1);
         begin
            wait_cycle(d + 153);
            chk("coincide_pre_rxdata", bus.rxdata, 8'h42);
            wait_cycle(d + 154);
            bus.data_read = 1'b0;
            wait_cycle(d + 155);
            chk("coincide_rxrecv", bus.rxrecv, 1);
            chk("coincide_rxdata", bus.rxdata, 8'h99);
         end
      join
      m_data = 8'h99;
      repeat (4) @(negedge clk);
      check_hold("post_coincide");
      d = cyc;
      rx = 1'b0;
      wait_cycle(d + 12);
      bus.txdata = 8'h00;
      bus.txbegin = 1'b1;
      wait_cycle(d + 13);
      bus.txbegin = 1'b0;
      wait_cycle(d + 85);
      chk("midframe_txbusy", bus.txbusy, 1);
      chk("midframe_tx", tx, 0);
      wait_cycle(d + 86);
      rst = 1'b1;
      rx = 1'b1;
      wait_cycle(d + 87);
      rst = 1'b0;
      m_full = 1'b0;
      m_data = 8'h00;
      chk("abort_tx", tx, 1);
      chk("abort_txbusy", bus.txbusy, 0);
      check_hold("abort");
      repeat (4) @(negedge clk);
      fork
         send_tx(8'hFF);
         rx_frame(8'hFF, 1'b1);
      join
      repeat (2) @(negedge clk);
      m_full = 1'b1;
      m_data = 8'hFF;
      check_hold("after_abort");
      for (int r = 0; r < 16; r++) begin
         rb = 8'($urandom);
         tb_b = 8'($urandom);
         stop = ($urandom % 5) != 0;
         if ($urandom % 2) drain($urandom_range(1, 6));
         @(negedge clk);
         fork
            send_tx(tb_b);
            rx_frame(rb, stop);
         join
         if (stop && !m_full) m_data = rb;
         if (stop) m_full = 1'b1;
         repeat (4) @(negedge clk);
         check_hold($sformatf("rand%0d", r));
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
